// File: rtl/ppfifo_adapter_pkg.sv
// Shared types and constants for the AXI-Stream to ping-pong FIFO packer.
package ppfifo_adapter_pkg;

  localparam int PPFIFO_SIZE_WIDTH = 24;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/axis_lane_packer.sv
// Collects RATIO stream beats into one wide word, beat 0 in the LSBs.
// word_next is the word as it would look after the current beat lands; the
// lanes clear whenever the index returns to 0, so a later word never picks up
// bytes left over from an earlier one.
module axis_lane_packer
  import ppfifo_adapter_pkg::*;
#(
  parameter int AXI_WIDTH    = 32,
  parameter int RATIO        = 2,
  parameter int STROBE_WIDTH = AXI_WIDTH / 8,
  parameter int USE_KEEP     = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          lane_wr,
  input  logic [AXI_WIDTH-1:0]          data,
  input  logic [STROBE_WIDTH-1:0]       keep,
  output logic                          word_complete,
  output logic                          partial,
  output logic [AXI_WIDTH*RATIO-1:0]    word_next
);

  localparam int IDX_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(RATIO - 1);

  logic [RATIO-1:0][AXI_WIDTH-1:0] lanes;
  logic [IDX_WIDTH-1:0]            idx;
  logic [AXI_WIDTH-1:0]            beat_masked;

  assign word_complete = lane_wr && (idx == LAST_IDX);
  assign partial       = (idx != '0);

  // Zero the bytes whose keep bit is low when keep masking is enabled.
  always_comb begin
    beat_masked = data;
    if (USE_KEEP != 0) begin
      for (int b = 0; b < STROBE_WIDTH; b++) begin
        if (!keep[b]) beat_masked[b*8 +: 8] = 8'h00;
      end
    end
  end

  // Word as seen after the current beat is placed into its lane.
  always_comb begin
    word_next = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (lane_wr && (idx == IDX_WIDTH'(i)))
        word_next[i*AXI_WIDTH +: AXI_WIDTH] = beat_masked;
      else
        word_next[i*AXI_WIDTH +: AXI_WIDTH] = lanes[i];
    end
  end

  // Lane storage and write index; a completed or abandoned word empties the lanes.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lanes <= '0;
      idx   <= '0;
    end else if (lane_wr) begin
      if (idx == LAST_IDX) begin
        lanes <= '0;
        idx   <= '0;
      end else begin
        for (int i = 0; i < RATIO; i++) begin
          if (idx == IDX_WIDTH'(i)) lanes[i] <= beat_masked;
        end
        idx <= idx + IDX_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/adapter_axi_stream_2_ppfifo_packer.sv
// AXI-Stream slave feeding the write side of a ping-pong FIFO, packing RATIO
// beats per FIFO word, with TLAST / idle-timeout flush and fair buffer choice.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | no buffer held; wait for a ready flag and pick a buffer
//   FILL    | buffer active; accept beats, strobe out each completed word
//   FLUSH   | partial word strobed out (unfilled lanes zero)
//   RELEASE | drop activate, remember which buffer was used
module adapter_axi_stream_2_ppfifo_packer
  import ppfifo_adapter_pkg::*;
#(
  parameter int AXI_WIDTH    = 32,
  parameter int RATIO        = 2,
  parameter int STROBE_WIDTH = AXI_WIDTH / 8,
  parameter int USE_KEEP     = 0,
  parameter int TIMEOUT      = 0
) (
  input  logic                          i_axi_clk,
  input  logic                          rst,
  output logic                          o_axi_ready,
  input  logic [AXI_WIDTH-1:0]          i_axi_data,
  input  logic [STROBE_WIDTH-1:0]       i_axi_keep,
  input  logic                          i_axi_last,
  input  logic                          i_axi_valid,
  output logic                          o_ppfifo_clk,
  input  logic [1:0]                    i_ppfifo_rdy,
  output logic [1:0]                    o_ppfifo_act,
  input  logic [PPFIFO_SIZE_WIDTH-1:0]  i_ppfifo_size,
  output logic                          o_ppfifo_stb,
  output logic [AXI_WIDTH*RATIO-1:0]    o_ppfifo_data,
  output logic                          o_timeout
);

  localparam int WORD_WIDTH = AXI_WIDTH * RATIO;
  localparam int IDLE_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t                         state, state_next;
  logic [PPFIFO_SIZE_WIDTH-1:0]   r_count, count_next;
  logic [IDLE_WIDTH-1:0]          idle_cnt;
  logic                           last_used, last_next;
  logic [1:0]                     act_next;
  logic                           stb_next, timeout_next;
  logic [WORD_WIDTH-1:0]          data_next, word_next;
  logic                           accept, keep_zero, lane_wr;
  logic                           word_complete, partial;
  logic                           count_full, count_last, timeout_fire, clear;

  assign o_ppfifo_clk = i_axi_clk;
  assign o_axi_ready  = (state == ST_FILL) && (r_count < i_ppfifo_size);
  assign accept       = i_axi_valid && o_axi_ready;
  assign keep_zero    = (USE_KEEP != 0) && (i_axi_keep == '0);
  assign lane_wr      = accept && !keep_zero;
  assign count_full   = (r_count >= i_ppfifo_size);
  // Widened so a capacity at the top of the 24-bit range cannot wrap.
  assign count_last   = (({1'b0, r_count} + 25'd1) >= {1'b0, i_ppfifo_size});
  // An empty buffer never times out; it keeps waiting for data.
  assign timeout_fire = (TIMEOUT != 0) && (idle_cnt == IDLE_WIDTH'(TIMEOUT)) &&
                        (partial || (r_count != '0));
  assign clear        = (state_next != ST_FILL);

  axis_lane_packer #(
    .AXI_WIDTH   (AXI_WIDTH),
    .RATIO       (RATIO),
    .STROBE_WIDTH(STROBE_WIDTH),
    .USE_KEEP    (USE_KEEP)
  ) u_packer (
    .clk          (i_axi_clk),
    .rst          (rst),
    .clear        (clear),
    .lane_wr      (lane_wr),
    .data         (i_axi_data),
    .keep         (i_axi_keep),
    .word_complete(word_complete),
    .partial      (partial),
    .word_next    (word_next)
  );

  // Next-state selection.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (i_ppfifo_rdy != 2'b00) state_next = ST_FILL;
      ST_FILL: begin
        if (accept) begin
          if (word_complete) begin
            if (i_axi_last || count_last) state_next = ST_RELEASE;
          end else if (i_axi_last) begin
            state_next = (lane_wr || partial) ? ST_FLUSH : ST_RELEASE;
          end
        end else if (count_full || timeout_fire) begin
          state_next = partial ? ST_FLUSH : ST_RELEASE;
        end
      end
      ST_FLUSH:   state_next = ST_RELEASE;
      ST_RELEASE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, word counter and buffer history.
  always_comb begin
    act_next     = o_ppfifo_act;
    stb_next     = 1'b0;
    data_next    = o_ppfifo_data;
    count_next   = r_count;
    last_next    = last_used;
    timeout_next = 1'b0;
    case (state)
      ST_IDLE: begin
        act_next   = 2'b00;
        count_next = '0;
        if (i_ppfifo_rdy == 2'b11) act_next = last_used ? 2'b01 : 2'b10;
        else if (i_ppfifo_rdy[0])  act_next = 2'b01;
        else if (i_ppfifo_rdy[1])  act_next = 2'b10;
      end
      ST_FILL: begin
        if (word_complete || (state_next == ST_FLUSH)) begin
          stb_next   = 1'b1;
          data_next  = word_next;
          count_next = r_count + PPFIFO_SIZE_WIDTH'(1);
        end
        timeout_next = !accept && !count_full && timeout_fire;
      end
      ST_RELEASE: begin
        act_next  = 2'b00;
        last_next = o_ppfifo_act[1];
      end
      default: ;
    endcase
  end

  // State and registered outputs; reset abandons any partial word silently.
  always_ff @(posedge i_axi_clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      r_count       <= '0;
      last_used     <= 1'b1;
      o_ppfifo_act  <= 2'b00;
      o_ppfifo_stb  <= 1'b0;
      o_ppfifo_data <= '0;
      o_timeout     <= 1'b0;
    end else begin
      state         <= state_next;
      r_count       <= count_next;
      last_used     <= last_next;
      o_ppfifo_act  <= act_next;
      o_ppfifo_stb  <= stb_next;
      o_ppfifo_data <= data_next;
      o_timeout     <= timeout_next;
    end
  end

  // Saturating count of FILL cycles with no accepted beat.
  always_ff @(posedge i_axi_clk) begin
    if (rst || (state != ST_FILL) || accept)
      idle_cnt <= '0;
    else if (idle_cnt != IDLE_WIDTH'(TIMEOUT))
      idle_cnt <= idle_cnt + IDLE_WIDTH'(1);
  end

endmodule
